lsu_l1d_req_sched: RTL

- In-order LSU-side scheduler between LSU dispatch and the L1D load/store request ports.
- Buffers load/store/fence uops in a circular LSQ and issues the oldest unissued entry to the L1D load or store port with a valid/ready handshake.
- Tracks issued loads until writeback, re-issues replayed loads, and enforces store/fence ordering and kill flush.

---
 rtl/lsq_sched_pkg.sv | 50 +++++
 rtl/lsu_l1d_req_sched_retire_scan.sv | 38 +++
 rtl/lsu_l1d_req_sched.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/lsq_sched_pkg.sv
// Shared types, widths and address-split helpers for the LSU-side L1D request scheduler.
package lsq_sched_pkg;

    localparam int LSU_ADDR_PIPE_COUNT = 1;
    localparam int LSU_DATA_PIPE_COUNT = 1;

    localparam int ROB_INDEX_WIDTH  = 6;
    localparam int ROB_TAG_WIDTH    = ROB_INDEX_WIDTH;
    localparam int PREG_TAG_WIDTH   = 6;
    localparam int LDU_OP_WIDTH     = 4;
    localparam int STU_OP_WIDTH     = 4;
    localparam int PADDR_WIDTH      = 32;
    localparam int XLEN             = 64;

    // L1D geometry: 64-byte lines, 256 sets; the remaining upper bits form the tag.
    localparam int L1D_OFFSET_WIDTH = 6;
    localparam int L1D_INDEX_WIDTH  = 8;
    localparam int L1D_TAG_WIDTH    = PADDR_WIDTH - L1D_INDEX_WIDTH - L1D_OFFSET_WIDTH;

    typedef enum logic [1:0] {
        LSQ_FREE   = 2'd0,
        LSQ_VALID  = 2'd1,
        LSQ_ISSUED = 2'd2
    } lsq_state_e;

    typedef struct packed {
        lsq_state_e                state;
        logic                      is_store;
        logic                      is_fence;
        logic [ROB_TAG_WIDTH-1:0]  rob_index;
        logic [PREG_TAG_WIDTH-1:0] rd_addr;
        logic [LDU_OP_WIDTH-1:0]   ld_opcode;
        logic [STU_OP_WIDTH-1:0]   st_opcode;
        logic [PADDR_WIDTH-1:0]    paddr;
        logic [XLEN-1:0]           data;
    } lsq_entry_t;

    function automatic logic [L1D_OFFSET_WIDTH-1:0] paddr_offset(input logic [PADDR_WIDTH-1:0] paddr);
        return paddr[L1D_OFFSET_WIDTH-1:0];
    endfunction

    function automatic logic [L1D_INDEX_WIDTH-1:0] paddr_index(input logic [PADDR_WIDTH-1:0] paddr);
        return paddr[L1D_OFFSET_WIDTH +: L1D_INDEX_WIDTH];
    endfunction

    function automatic logic [L1D_TAG_WIDTH-1:0] paddr_tag(input logic [PADDR_WIDTH-1:0] paddr);
        return paddr[PADDR_WIDTH-1 -: L1D_TAG_WIDTH];
    endfunction

endpackage

// File: rtl/lsu_l1d_req_sched_retire_scan.sv
// Finds the new LSQ head: the first non-FREE entry at or after head, stopping at tail.
module lsq_retire_scan
    import lsq_sched_pkg::*;
#(
    parameter int LSQ_ENTRY_NUM       = 8,
    parameter int LSQ_ENTRY_NUM_WIDTH = 3
) (
    input  logic [LSQ_ENTRY_NUM_WIDTH:0]  head_ptr,
    input  logic [LSQ_ENTRY_NUM_WIDTH:0]  tail_ptr,
    input  logic [LSQ_ENTRY_NUM-1:0]      entry_free,
    output logic [LSQ_ENTRY_NUM_WIDTH:0]  head_ptr_nxt
);

    typedef logic [LSQ_ENTRY_NUM_WIDTH:0] ptr_t;

    ptr_t occupied;
    ptr_t offs;
    ptr_t slot;
    logic found;

    // Priority scan from head; an empty queue or an all-retired window resolves to tail.
    always_comb begin
        occupied     = tail_ptr - head_ptr;
        head_ptr_nxt = tail_ptr;
        found        = 1'b0;
        offs         = '0;
        slot         = head_ptr;
        for (int i = 0; i < LSQ_ENTRY_NUM; i++) begin
            offs = ptr_t'(i);
            slot = head_ptr + offs;
            if (!found && ((offs == occupied) || !entry_free[slot[LSQ_ENTRY_NUM_WIDTH-1:0]])) begin
                head_ptr_nxt = slot;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lsu_l1d_req_sched.sv
// In-order LSQ that issues loads, stores and fences from LSU dispatch to the L1D request ports.
module lsu_l1d_req_sched
    import lsq_sched_pkg::*;
#(
    parameter int LSQ_ENTRY_NUM       = 8,
    parameter int LSQ_ENTRY_NUM_WIDTH = 3,
    parameter int WB_PORT_NUM         = LSU_ADDR_PIPE_COUNT + LSU_DATA_PIPE_COUNT
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   lsu_req_vld_i,
    output logic                                   lsu_req_rdy_o,
    input  logic                                   lsu_req_is_store_i,
    input  logic                                   lsu_req_is_fence_i,
    input  logic [ROB_TAG_WIDTH-1:0]               lsu_req_rob_index_i,
    input  logic [PREG_TAG_WIDTH-1:0]              lsu_req_rd_addr_i,
    input  logic [LDU_OP_WIDTH-1:0]                lsu_req_ld_opcode_i,
    input  logic [STU_OP_WIDTH-1:0]                lsu_req_st_opcode_i,
    input  logic [PADDR_WIDTH-1:0]                 lsu_req_paddr_i,
    input  logic [XLEN-1:0]                        lsu_req_data_i,
    output logic                                   l1d_ld_req_vld_o,
    input  logic                                   l1d_ld_req_rdy_i,
    output logic [ROB_TAG_WIDTH-1:0]               l1d_ld_req_rob_index_o,
    output logic [PREG_TAG_WIDTH-1:0]              l1d_ld_req_rd_addr_o,
    output logic [LDU_OP_WIDTH-1:0]                l1d_ld_req_opcode_o,
    output logic [L1D_INDEX_WIDTH-1:0]             l1d_ld_req_index_o,
    output logic [L1D_OFFSET_WIDTH-1:0]            l1d_ld_req_offset_o,
    output logic [L1D_TAG_WIDTH-1:0]               l1d_ld_req_vtag_o,
    output logic                                   l1d_st_req_vld_o,
    input  logic                                   l1d_st_req_rdy_i,
    output logic                                   l1d_st_req_is_fence_o,
    output logic [ROB_TAG_WIDTH-1:0]               l1d_st_req_rob_index_o,
    output logic [PREG_TAG_WIDTH-1:0]              l1d_st_req_rd_addr_o,
    output logic [STU_OP_WIDTH-1:0]                l1d_st_req_opcode_o,
    output logic [PADDR_WIDTH-1:0]                 l1d_st_req_paddr_o,
    output logic [XLEN-1:0]                        l1d_st_req_data_o,
    input  logic                                   l1d_ld_replay_vld_i,
    input  logic [WB_PORT_NUM-1:0]                 l1d_wb_vld_i,
    input  logic [WB_PORT_NUM*ROB_INDEX_WIDTH-1:0] l1d_wb_rob_index_i,
    input  logic                                   flush_i,
    output logic                                   lsu_l1d_kill_req_o,
    output logic                                   lsq_empty_o
);

    localparam int IW = LSQ_ENTRY_NUM_WIDTH;

    typedef logic [IW:0]   ptr_t;
    typedef logic [IW-1:0] idx_t;

    lsq_entry_t               entry_q [LSQ_ENTRY_NUM];
    lsq_state_e               state_d [LSQ_ENTRY_NUM];
    logic [LSQ_ENTRY_NUM-1:0] entry_free_d;

    ptr_t       head_q, iss_q, tail_q;
    ptr_t       head_d, iss_d, tail_d;
    ptr_t       last_ld_ptr_q;
    logic       last_ld_fire_q;
    logic [1:0] fence_cnt_q;
    logic       kill_q;

    idx_t       head_idx, iss_idx, tail_idx, last_ld_idx;
    logic       full, empty;
    lsq_entry_t iss_entry;
    logic       iss_is_st, iss_ready;
    logic       ld_vld, st_vld;
    logic       enq_fire, ld_fire, st_fire, replay_hit;

    assign head_idx    = head_q[IW-1:0];
    assign iss_idx     = iss_q[IW-1:0];
    assign tail_idx    = tail_q[IW-1:0];
    assign last_ld_idx = last_ld_ptr_q[IW-1:0];

    assign empty = (head_q == tail_q);
    assign full  = (head_q[IW] != tail_q[IW]) && (head_idx == tail_idx);

    assign lsu_req_rdy_o = ~full;
    assign lsq_empty_o   = empty;
    assign enq_fire      = lsu_req_vld_i & lsu_req_rdy_o;

    // Issue candidate is always the entry at iss; stores wait until nothing older is outstanding.
    assign iss_entry = entry_q[iss_idx];
    assign iss_is_st = iss_entry.is_store | iss_entry.is_fence;
    assign iss_ready = (iss_q != tail_q) && (iss_entry.state == LSQ_VALID) &&
                       (fence_cnt_q == 2'd0) && !flush_i;
    assign ld_vld    = iss_ready & ~iss_is_st;
    assign st_vld    = iss_ready & iss_is_st & (iss_q == head_q);

    // A load handshake offered in the replay cycle is dropped; the replayed load reissues first.
    assign replay_hit = l1d_ld_replay_vld_i & last_ld_fire_q;
    assign ld_fire    = ld_vld & l1d_ld_req_rdy_i & ~replay_hit;
    assign st_fire    = st_vld & l1d_st_req_rdy_i;

    assign l1d_ld_req_vld_o       = ld_vld;
    assign l1d_ld_req_rob_index_o = ld_vld ? iss_entry.rob_index : '0;
    assign l1d_ld_req_rd_addr_o   = ld_vld ? iss_entry.rd_addr : '0;
    assign l1d_ld_req_opcode_o    = ld_vld ? iss_entry.ld_opcode : '0;
    assign l1d_ld_req_index_o     = ld_vld ? paddr_index(iss_entry.paddr) : '0;
    assign l1d_ld_req_offset_o    = ld_vld ? paddr_offset(iss_entry.paddr) : '0;
    assign l1d_ld_req_vtag_o      = ld_vld ? paddr_tag(iss_entry.paddr) : '0;

    assign l1d_st_req_vld_o       = st_vld;
    assign l1d_st_req_is_fence_o  = st_vld ? iss_entry.is_fence : 1'b0;
    assign l1d_st_req_rob_index_o = st_vld ? iss_entry.rob_index : '0;
    assign l1d_st_req_rd_addr_o   = st_vld ? iss_entry.rd_addr : '0;
    assign l1d_st_req_opcode_o    = st_vld ? iss_entry.st_opcode : '0;
    assign l1d_st_req_paddr_o     = st_vld ? iss_entry.paddr : '0;
    assign l1d_st_req_data_o      = st_vld ? iss_entry.data : '0;

    assign lsu_l1d_kill_req_o = kill_q;

    // Next entry states: enqueue, issue, store retire, writeback retire, then replay on top.
    always_comb begin
        for (int i = 0; i < LSQ_ENTRY_NUM; i++) begin
            state_d[i] = entry_q[i].state;
        end
        if (enq_fire) begin
            state_d[tail_idx] = LSQ_VALID;
        end
        if (ld_fire) begin
            state_d[iss_idx] = LSQ_ISSUED;
        end
        if (st_fire) begin
            state_d[iss_idx] = LSQ_FREE;
        end
        for (int i = 0; i < LSQ_ENTRY_NUM; i++) begin
            for (int k = 0; k < WB_PORT_NUM; k++) begin
                if (l1d_wb_vld_i[k] && (entry_q[i].state == LSQ_ISSUED) &&
                    (entry_q[i].rob_index == l1d_wb_rob_index_i[k*ROB_INDEX_WIDTH +: ROB_INDEX_WIDTH])) begin
                    state_d[i] = LSQ_FREE;
                end
            end
        end
        if (replay_hit) begin
            state_d[last_ld_idx] = LSQ_VALID;
        end
        for (int i = 0; i < LSQ_ENTRY_NUM; i++) begin
            entry_free_d[i] = (state_d[i] == LSQ_FREE);
        end
    end

    // Next issue and tail pointers; replay rewinds iss ahead of any increment.
    always_comb begin
        iss_d  = iss_q;
        tail_d = tail_q;
        if (replay_hit) begin
            iss_d = last_ld_ptr_q;
        end else if (ld_fire || st_fire) begin
            iss_d = iss_q + ptr_t'(1);
        end
        if (enq_fire) begin
            tail_d = tail_q + ptr_t'(1);
        end
    end

    lsq_retire_scan #(
        .LSQ_ENTRY_NUM       (LSQ_ENTRY_NUM),
        .LSQ_ENTRY_NUM_WIDTH (LSQ_ENTRY_NUM_WIDTH)
    ) u_retire_scan (
        .head_ptr     (head_q),
        .tail_ptr     (tail_q),
        .entry_free   (entry_free_d),
        .head_ptr_nxt (head_d)
    );

    // Queue state, pointers, replay/fence tracking and payload capture; payload is never reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q         <= '0;
            iss_q          <= '0;
            tail_q         <= '0;
            last_ld_ptr_q  <= '0;
            last_ld_fire_q <= 1'b0;
            fence_cnt_q    <= 2'd0;
            kill_q         <= 1'b0;
            for (int i = 0; i < LSQ_ENTRY_NUM; i++) begin
                entry_q[i].state <= LSQ_FREE;
            end
        end else if (flush_i) begin
            head_q         <= '0;
            iss_q          <= '0;
            tail_q         <= '0;
            last_ld_fire_q <= 1'b0;
            fence_cnt_q    <= 2'd0;
            kill_q         <= 1'b1;
            for (int i = 0; i < LSQ_ENTRY_NUM; i++) begin
                entry_q[i].state <= LSQ_FREE;
            end
        end else begin
            head_q         <= head_d;
            iss_q          <= iss_d;
            tail_q         <= tail_d;
            last_ld_fire_q <= ld_fire;
            kill_q         <= 1'b0;
            if (ld_fire) begin
                last_ld_ptr_q <= iss_q;
            end
            if (st_fire && iss_entry.is_fence) begin
                fence_cnt_q <= 2'd2;
            end else if (fence_cnt_q != 2'd0) begin
                fence_cnt_q <= fence_cnt_q - 2'd1;
            end
            for (int i = 0; i < LSQ_ENTRY_NUM; i++) begin
                entry_q[i].state <= state_d[i];
            end
            if (enq_fire) begin
                entry_q[tail_idx].is_store  <= lsu_req_is_store_i;
                entry_q[tail_idx].is_fence  <= lsu_req_is_fence_i;
                entry_q[tail_idx].rob_index <= lsu_req_rob_index_i;
                entry_q[tail_idx].rd_addr   <= lsu_req_rd_addr_i;
                entry_q[tail_idx].ld_opcode <= lsu_req_ld_opcode_i;
                entry_q[tail_idx].st_opcode <= lsu_req_st_opcode_i;
                entry_q[tail_idx].paddr     <= lsu_req_paddr_i;
                entry_q[tail_idx].data      <= lsu_req_data_i;
            end
        end
    end

endmodule
